// File: rtl/adder_tree_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adder_tree_pkg: width helpers and output conversion for the tree   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package adder_tree_pkg;

  localparam int CONV_W = 64;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int tree_width(input int addend_width, input int num_addend);
    return addend_width + clog2(num_addend);
  endfunction

  function automatic int acc_width(input int addend_width, input int num_addend,
                                   input int num_beat);
    return tree_width(addend_width, num_addend) + clog2(num_beat);
  endfunction

  // Bit offset of level k inside the flattened tree bus (level 0 = raw addends).
  function automatic int level_offset(input int addend_width, input int num_addend,
                                      input int level);
    int off;
    off = 0;
    for (int j = 0; j < level; j++) off += (num_addend >> j) * (addend_width + j);
    return off;
  endfunction

  // Returns {sat_flag, result}; result is sign-correct in its low sum_width bits.
  function automatic logic [CONV_W:0] sat_convert(input logic signed [CONV_W-1:0] value,
                                                  input int aw, input int sum_width,
                                                  input bit sat_en);
    logic signed [CONV_W-1:0] max_v;
    logic signed [CONV_W-1:0] min_v;
    logic signed [CONV_W-1:0] wrap_v;
    logic signed [CONV_W-1:0] res;
    logic                     sat;
    res = value;
    sat = 1'b0;
    if (sum_width < aw) begin
      max_v  = (64'sd1 <<< (sum_width - 1)) - 64'sd1;
      min_v  = -(64'sd1 <<< (sum_width - 1));
      wrap_v = (value <<< (CONV_W - sum_width)) >>> (CONV_W - sum_width);
      if (sat_en) begin
        if (value > max_v) begin
          res = max_v;
          sat = 1'b1;
        end else if (value < min_v) begin
          res = min_v;
          sat = 1'b1;
        end
      end else begin
        res = wrap_v;
        sat = (wrap_v != value);
      end
    end
    return {sat, res};
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_tree_acc_level.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adder_tree_level: one registered pairwise-add stage with valid_n   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int IN_NUM   = 2,
  parameter int IN_WIDTH = 8
) (
  input  logic                                 clk_p,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic [IN_NUM*IN_WIDTH-1:0]           din,
  input  logic                                 din_valid_n,
  output logic [(IN_NUM/2)*(IN_WIDTH+1)-1:0]   dout,
  output logic                                 dout_valid_n
);

  localparam int OUT_NUM   = IN_NUM / 2;
  localparam int OUT_WIDTH = IN_WIDTH + 1;

  logic [OUT_NUM*OUT_WIDTH-1:0] pair_sum;

  for (genvar i = 0; i < OUT_NUM; i++) begin : g_pair
    logic signed [IN_WIDTH-1:0] a;
    logic signed [IN_WIDTH-1:0] b;
    assign a = din[(2*i)*IN_WIDTH +: IN_WIDTH];
    assign b = din[(2*i+1)*IN_WIDTH +: IN_WIDTH];
    assign pair_sum[i*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(a) + OUT_WIDTH'(b);
  end

  // Data only loads on a valid beat; flush drops the in-flight beat but keeps data.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      dout         <= '0;
      dout_valid_n <= 1'b1;
    end else if (flush) begin
      dout_valid_n <= 1'b1;
    end else begin
      dout_valid_n <= din_valid_n;
      if (!din_valid_n) dout <= pair_sum;
    end
  end

endmodule
`default_nettype wire

// File: rtl/adder_tree_acc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adder_tree_acc: pipelined signed adder tree, multi-beat accumulate |
// | and saturating output.                   Revision: 1.0             |
// +--------------------------------------------------------------------+
module adder_tree_acc
  import adder_tree_pkg::*;
#(
  parameter int ADDEND_WIDTH = 8,
  parameter int NUM_ADDEND   = 128,
  parameter int NUM_BEAT     = 1,
  parameter int SUM_WIDTH    = 15,
  parameter int SAT_EN       = 1
) (
  input  logic                               clk_p,
  input  logic                               rst_n,
  input  logic [ADDEND_WIDTH*NUM_ADDEND-1:0] addend,
  input  logic                               addend_valid_n,
  input  logic                               acc_clr_n,
  output logic [SUM_WIDTH-1:0]               sum,
  output logic                               sum_valid_n,
  output logic                               sum_sat
);

  localparam int L       = clog2(NUM_ADDEND);
  localparam int TW      = tree_width(ADDEND_WIDTH, NUM_ADDEND);
  localparam int AW      = acc_width(ADDEND_WIDTH, NUM_ADDEND, NUM_BEAT);
  localparam int CW      = (NUM_BEAT > 1) ? clog2(NUM_BEAT) : 1;
  localparam int BUS_W   = level_offset(ADDEND_WIDTH, NUM_ADDEND, L + 1);
  localparam int OUT_OFF = level_offset(ADDEND_WIDTH, NUM_ADDEND, L);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_BEAT - 1);

  logic [BUS_W-1:0] tree_bus;
  logic [L:0]       lvl_valid_n;
  logic             flush;

  assign flush                                = ~acc_clr_n;
  assign tree_bus[0 +: NUM_ADDEND*ADDEND_WIDTH] = addend;
  assign lvl_valid_n[0]                       = addend_valid_n;

  for (genvar k = 0; k < L; k++) begin : g_level
    localparam int IN_OFF   = level_offset(ADDEND_WIDTH, NUM_ADDEND, k);
    localparam int NXT_OFF  = level_offset(ADDEND_WIDTH, NUM_ADDEND, k + 1);
    localparam int IN_NUM   = NUM_ADDEND >> k;
    localparam int IN_WIDTH = ADDEND_WIDTH + k;

    adder_tree_level #(
      .IN_NUM   (IN_NUM),
      .IN_WIDTH (IN_WIDTH)
    ) u_level (
      .clk_p        (clk_p),
      .rst_n        (rst_n),
      .flush        (flush),
      .din          (tree_bus[IN_OFF +: IN_NUM*IN_WIDTH]),
      .din_valid_n  (lvl_valid_n[k]),
      .dout         (tree_bus[NXT_OFF +: (IN_NUM/2)*(IN_WIDTH+1)]),
      .dout_valid_n (lvl_valid_n[k+1])
    );
  end

  logic signed [TW-1:0] tree_out;
  logic signed [AW-1:0] tree_ext;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next;
  logic [CW-1:0]        cnt;
  logic                 conv_sat;
  logic [CONV_W-SUM_WIDTH-1:0] conv_unused;
  logic [SUM_WIDTH-1:0] conv_sum;

  assign tree_out = $signed(tree_bus[OUT_OFF +: TW]);
  assign tree_ext = AW'(tree_out);

  always_comb begin
    acc_next = (cnt == '0) ? tree_ext : acc + tree_ext;
  end

  assign {conv_sat, conv_unused, conv_sum} =
      sat_convert(CONV_W'(acc_next), AW, SUM_WIDTH, SAT_EN != 0);

  // sum holds between results; sum_valid_n and sum_sat pulse with each result.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      cnt         <= '0;
      sum         <= '0;
      sum_valid_n <= 1'b1;
      sum_sat     <= 1'b0;
    end else if (!acc_clr_n) begin
      acc         <= '0;
      cnt         <= '0;
      sum_valid_n <= 1'b1;
      sum_sat     <= 1'b0;
    end else begin
      sum_valid_n <= 1'b1;
      sum_sat     <= 1'b0;
      if (!lvl_valid_n[L]) begin
        acc <= acc_next;
        if (cnt == LAST_BEAT) begin
          cnt         <= '0;
          sum         <= conv_sum;
          sum_sat     <= conv_sat;
          sum_valid_n <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_acc.sv
`default_nettype none
// Directed bench for adder_tree_acc: 8 addends x 8 bits, 2 beats, 10-bit saturating sum.
module tb_adder_tree_acc;

  localparam int ADDEND_WIDTH = 8;
  localparam int NUM_ADDEND   = 8;
  localparam int NUM_BEAT     = 2;
  localparam int SUM_WIDTH    = 10;
  localparam int SAT_EN       = 1;

  logic                        clk_p = 1'b0;
  logic                        rst_n;
  logic [63:0]                 addend;
  logic                        addend_valid_n;
  logic                        acc_clr_n;
  logic signed [SUM_WIDTH-1:0] sum;
  logic                        sum_valid_n;
  logic                        sum_sat;

  int errors = 0;
  int checks = 0;

  always #5 clk_p = ~clk_p;

  adder_tree_acc #(
    .ADDEND_WIDTH (ADDEND_WIDTH),
    .NUM_ADDEND   (NUM_ADDEND),
    .NUM_BEAT     (NUM_BEAT),
    .SUM_WIDTH    (SUM_WIDTH),
    .SAT_EN       (SAT_EN)
  ) dut (
    .clk_p          (clk_p),
    .rst_n          (rst_n),
    .addend         (addend),
    .addend_valid_n (addend_valid_n),
    .acc_clr_n      (acc_clr_n),
    .sum            (sum),
    .sum_valid_n    (sum_valid_n),
    .sum_sat        (sum_sat)
  );

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all8(input logic [7:0] x);
    return {8{x}};
  endfunction

  // Drives one valid beat for one cycle; returns in the following cycle.
  task automatic beat(input logic [63:0] v);
    addend         = v;
    addend_valid_n = 1'b0;
    tick();
    addend_valid_n = 1'b1;
    addend         = '0;
  endtask

  // Called one cycle after the final beat (beat in cycle c, now c+1); result is due in c+4.
  task automatic expect_result(input string tag, input int exp_sum, input int exp_sat,
                               input int prev_sum);
    for (int i = 0; i < 3; i++) begin
      chk({tag, " early valid_n"}, 32'(sum_valid_n), 1);
      chk({tag, " held sum"}, 32'(sum), prev_sum);
      tick();
    end
    chk({tag, " valid_n"}, 32'(sum_valid_n), 0);
    chk({tag, " sum"}, 32'(sum), exp_sum);
    chk({tag, " sat"}, 32'(sum_sat), exp_sat);
    tick();
    chk({tag, " valid_n drop"}, 32'(sum_valid_n), 1);
    chk({tag, " sum after"}, 32'(sum), exp_sum);
    chk({tag, " sat after"}, 32'(sum_sat), 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    acc_clr_n      = 1'b1;
    addend_valid_n = 1'b1;
    addend         = '0;
    tick();
    tick();
    chk("reset sum", 32'(sum), 0);
    chk("reset valid_n", 32'(sum_valid_n), 1);
    chk("reset sat", 32'(sum_sat), 0);
    rst_n = 1'b1;
    tick();

    // 8*1 + 8*1
    beat(all8(8'd1));
    beat(all8(8'd1));
    expect_result("basic", 16, 0, 0);

    // 2*8*127 = 2032 clamps to 511
    beat(all8(8'd127));
    beat(all8(8'd127));
    expect_result("pos sat", 511, 1, 16);

    // 2*8*(-128) = -2048 clamps to -512
    beat(all8(8'h80));
    beat(all8(8'h80));
    expect_result("neg sat", -512, 1, 511);

    // {1,-2,3,-4,5,-6,7,-8} = -4, then all 10 = 80 -> 76
    beat({8'hF8, 8'h07, 8'hFA, 8'h05, 8'hFC, 8'h03, 8'hFE, 8'h01});
    for (int i = 0; i < 5; i++) begin
      chk("gap idle valid_n", 32'(sum_valid_n), 1);
      chk("gap idle sum", 32'(sum), -512);
      tick();
    end
    beat(all8(8'd10));
    expect_result("gap", 76, 0, -512);

    // Beat of 1s cleared in flight; only 16 + 24 is reported
    beat(all8(8'd1));
    acc_clr_n = 1'b0;
    tick();
    acc_clr_n = 1'b1;
    chk("clear valid_n", 32'(sum_valid_n), 1);
    beat(all8(8'd2));
    beat(all8(8'd3));
    expect_result("clear", 40, 0, 76);

    // Reset in flight; outputs return to reset values, then 32 + 32
    beat(all8(8'd1));
    rst_n = 1'b0;
    #1;
    chk("mid reset sum", 32'(sum), 0);
    chk("mid reset valid_n", 32'(sum_valid_n), 1);
    chk("mid reset sat", 32'(sum_sat), 0);
    tick();
    rst_n = 1'b1;
    tick();
    beat(all8(8'd4));
    beat(all8(8'd4));
    expect_result("after reset", 64, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
